// File: rtl/snake_body_if.sv
// Control/query bundle between the snake body engine and its direction, food and video clients.
interface snake_body_if #(
  parameter int X_BITS   = 5,
  parameter int Y_BITS   = 4,
  parameter int LEN_BITS = 5
);
  logic [1:0]          i_Dir;
  logic                i_Start;
  logic                i_Grow;
  logic [X_BITS-1:0]   i_Query_X;
  logic [Y_BITS-1:0]   i_Query_Y;
  logic [X_BITS-1:0]   o_Head_X;
  logic [Y_BITS-1:0]   o_Head_Y;
  logic [LEN_BITS-1:0] o_Len;
  logic                o_Step;
  logic                o_Game_Over;
  logic                o_Query_Hit;
  logic                o_Query_Head;

  modport master (output i_Dir, i_Start, i_Grow, i_Query_X, i_Query_Y,
                  input  o_Head_X, o_Head_Y, o_Len, o_Step, o_Game_Over, o_Query_Hit, o_Query_Head);
  modport slave  (input  i_Dir, i_Start, i_Grow, i_Query_X, i_Query_Y,
                  output o_Head_X, o_Head_Y, o_Len, o_Step, o_Game_Over, o_Query_Hit, o_Query_Head);
endinterface

// File: rtl/snake_body_engine.sv
// Snake body engine: move-tick timer, segment shift buffer, growth, wall/self collision, cell queries.
// Optional SNAKE_WRAP_EN: edges wrap to the opposite side instead of killing the snake.
module snake_body_engine #(
  parameter int GRID_W         = 20,
  parameter int GRID_H         = 15,
  parameter int X_BITS         = 5,
  parameter int Y_BITS         = 4,
  parameter int MAX_LEN        = 16,
  parameter int INIT_LEN       = 3,
  parameter int START_X        = 10,
  parameter int START_Y        = 7,
  parameter int TICKS_PER_STEP = 1250000
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  snake_body_if.slave  bus
);
  localparam int LEN_BITS  = $clog2(MAX_LEN + 1);
  localparam int TICK_BITS = $clog2(TICKS_PER_STEP);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  state_t               r_state, w_next;
  logic [X_BITS-1:0]    r_seg_x [MAX_LEN];
  logic [Y_BITS-1:0]    r_seg_y [MAX_LEN];
  logic [LEN_BITS-1:0]  r_len;
  logic [TICK_BITS-1:0] r_tick;
  logic                 r_grow_pend, r_step, r_qhit, r_qhead;

  logic                 w_step_cyc, w_grow_eff, w_wall, w_self, w_coll, w_move, w_reload, w_qhit;
  logic [X_BITS-1:0]    w_nx;
  logic [Y_BITS-1:0]    w_ny;

  function automatic logic [X_BITS-1:0] init_x(input int k);
    return (k < INIT_LEN) ? X_BITS'(START_X - k) : '0;
  endfunction

  function automatic logic [Y_BITS-1:0] init_y(input int k);
    return (k < INIT_LEN) ? Y_BITS'(START_Y) : '0;
  endfunction

  assign w_step_cyc = (r_state == S_RUN) && (r_tick == TICK_BITS'(TICKS_PER_STEP - 1));
  assign w_grow_eff = r_grow_pend | bus.i_Grow;
  assign w_reload   = (r_state == S_DEAD) && bus.i_Start;

  // Edge tests happen before the +/-1 so the coordinate never wraps through its bit width.
  always_comb begin
    w_nx   = r_seg_x[0];
    w_ny   = r_seg_y[0];
    w_wall = 1'b0;
    case (bus.i_Dir)
      2'b00: if (r_seg_y[0] == '0)
`ifdef SNAKE_WRAP_EN
               w_ny = Y_BITS'(GRID_H - 1);
`else
               w_wall = 1'b1;
`endif
             else w_ny = r_seg_y[0] - Y_BITS'(1);
      2'b01: if (r_seg_y[0] == Y_BITS'(GRID_H - 1))
`ifdef SNAKE_WRAP_EN
               w_ny = '0;
`else
               w_wall = 1'b1;
`endif
             else w_ny = r_seg_y[0] + Y_BITS'(1);
      2'b10: if (r_seg_x[0] == '0)
`ifdef SNAKE_WRAP_EN
               w_nx = X_BITS'(GRID_W - 1);
`else
               w_wall = 1'b1;
`endif
             else w_nx = r_seg_x[0] - X_BITS'(1);
      default: if (r_seg_x[0] == X_BITS'(GRID_W - 1))
`ifdef SNAKE_WRAP_EN
               w_nx = '0;
`else
               w_wall = 1'b1;
`endif
             else w_nx = r_seg_x[0] + X_BITS'(1);
    endcase
  end

  // The tail only blocks the new head when it is not vacating (growth pending).
  always_comb begin
    w_self = 1'b0;
    for (int k = 1; k < MAX_LEN; k++)
      if (((LEN_BITS'(k) < r_len - LEN_BITS'(1)) ||
           (w_grow_eff && LEN_BITS'(k) == r_len - LEN_BITS'(1))) &&
          r_seg_x[k] == w_nx && r_seg_y[k] == w_ny)
        w_self = 1'b1;
  end

  assign w_coll = w_wall | w_self;
  assign w_move = w_step_cyc && !w_coll;

  always_comb begin
    w_qhit = 1'b0;
    for (int k = 0; k < MAX_LEN; k++)
      if (LEN_BITS'(k) < r_len && r_seg_x[k] == bus.i_Query_X && r_seg_y[k] == bus.i_Query_Y)
        w_qhit = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_Start) w_next = S_RUN;
      S_RUN:   if (w_step_cyc && w_coll) w_next = S_DEAD;
      S_DEAD:  if (bus.i_Start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst)
    if (i_Rst) r_state <= S_IDLE;
    else       r_state <= w_next;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        r_seg_x[k] <= init_x(k);
        r_seg_y[k] <= init_y(k);
      end
      r_len       <= LEN_BITS'(INIT_LEN);
      r_tick      <= '0;
      r_grow_pend <= 1'b0;
      r_step      <= 1'b0;
      r_qhit      <= 1'b0;
      r_qhead     <= 1'b0;
    end else begin
      r_step  <= w_move;
      r_qhit  <= w_qhit;
      r_qhead <= (r_seg_x[0] == bus.i_Query_X) && (r_seg_y[0] == bus.i_Query_Y);
      if (w_reload) begin
        for (int k = 0; k < MAX_LEN; k++) begin
          r_seg_x[k] <= init_x(k);
          r_seg_y[k] <= init_y(k);
        end
        r_len       <= LEN_BITS'(INIT_LEN);
        r_tick      <= '0;
        r_grow_pend <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_tick <= w_step_cyc ? '0 : r_tick + TICK_BITS'(1);
        if (w_move) begin
          for (int k = 1; k < MAX_LEN; k++) begin
            r_seg_x[k] <= r_seg_x[k-1];
            r_seg_y[k] <= r_seg_y[k-1];
          end
          r_seg_x[0] <= w_nx;
          r_seg_y[0] <= w_ny;
          if (w_grow_eff && r_len < LEN_BITS'(MAX_LEN)) r_len <= r_len + LEN_BITS'(1);
          r_grow_pend <= 1'b0;
        end else if (bus.i_Grow) begin
          r_grow_pend <= 1'b1;
        end
      end
    end
  end

  assign bus.o_Head_X     = r_seg_x[0];
  assign bus.o_Head_Y     = r_seg_y[0];
  assign bus.o_Len        = r_len;
  assign bus.o_Step       = r_step;
  assign bus.o_Game_Over  = (r_state == S_DEAD);
  assign bus.o_Query_Hit  = r_qhit;
  assign bus.o_Query_Head = r_qhead;
endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine on an 8x8 grid, MAX_LEN 6, start (4,4), 4 clocks per step.
module tb_snake_body_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;

  snake_body_if #(.X_BITS(3), .Y_BITS(3), .LEN_BITS(3)) bus ();

  snake_body_engine #(
    .GRID_W(8), .GRID_H(8), .X_BITS(3), .Y_BITS(3), .MAX_LEN(6), .INIT_LEN(3),
    .START_X(4), .START_Y(4), .TICKS_PER_STEP(4)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Returns clocks until o_Step, or -1 when no step arrives within the budget.
  task automatic wait_step(output int cnt);
    cnt = 0;
    do begin cyc(); cnt++; end while (!bus.o_Step && cnt < 20);
    if (!bus.o_Step) cnt = -1;
  endtask

  task automatic head(input string tag, input int x, input int y);
    chk({tag, "_x"}, int'(bus.o_Head_X), x);
    chk({tag, "_y"}, int'(bus.o_Head_Y), y);
  endtask

  task automatic start();
    bus.i_Start = 1'b1; cyc(); bus.i_Start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  task automatic expect_death(input string tag, input int clocks);
    for (int i = 0; i < clocks; i++) begin
      cyc();
      chk({tag, "_nostep"}, int'(bus.o_Step), 0);
    end
    chk({tag, "_gameover"}, int'(bus.o_Game_Over), 1);
  endtask

  initial begin
    bus.i_Dir = 2'b11; bus.i_Start = 1'b0; bus.i_Grow = 1'b0;
    bus.i_Query_X = '0; bus.i_Query_Y = '0;

    // Reset state
    repeat (2) cyc();
    head("rst_head", 4, 4);
    chk("rst_len", int'(bus.o_Len), 3);
    chk("rst_step", int'(bus.o_Step), 0);
    chk("rst_go", int'(bus.o_Game_Over), 0);
    chk("rst_qhit", int'(bus.o_Query_Hit), 0);
    chk("rst_qhead", int'(bus.o_Query_Head), 0);
    rst = 1'b0;

    // Queries in IDLE
    bus.i_Query_X = 3'd4; bus.i_Query_Y = 3'd4; cyc();
    chk("q44_hit", int'(bus.o_Query_Hit), 1);
    chk("q44_head", int'(bus.o_Query_Head), 1);
    bus.i_Query_X = 3'd2; cyc();
    chk("q24_hit", int'(bus.o_Query_Hit), 1);
    chk("q24_head", int'(bus.o_Query_Head), 0);
    bus.i_Query_X = 3'd0; bus.i_Query_Y = 3'd0; cyc();
    chk("q00_hit", int'(bus.o_Query_Hit), 0);
    chk("q00_head", int'(bus.o_Query_Head), 0);

    // Move right three times
    bus.i_Dir = 2'b11;
    start();
    for (int s = 0; s < 3; s++) begin
      wait_step(n);
      chk("t1_lat", n, 4);
      head("t1_head", 5 + s, 4);
      chk("t1_len", int'(bus.o_Len), 3);
      chk("t1_go", int'(bus.o_Game_Over), 0);
    end

    // Right edge
`ifdef SNAKE_WRAP_EN
    wait_step(n);
    chk("wrap_lat", n, 4);
    head("wrap_head", 0, 4);
    chk("wrap_go", int'(bus.o_Game_Over), 0);
    do_reset();
`else
    expect_death("wall_r", 4);
    head("wall_r_head", 7, 4);
    chk("wall_r_len", int'(bus.o_Len), 3);
`endif

    // Restart (from DEAD without wrap) reloads the body
    start();
    head("restart_head", 4, 4);
    chk("restart_len", int'(bus.o_Len), 3);
    chk("restart_go", int'(bus.o_Game_Over), 0);
    wait_step(n);
    chk("restart_lat", n, 4);
    head("g_s1", 5, 4);

    // Two grow pulses between steps count once
    bus.i_Grow = 1'b1; cyc(); bus.i_Grow = 1'b0; cyc();
    bus.i_Grow = 1'b1; cyc(); bus.i_Grow = 1'b0;
    wait_step(n);
    head("g_s2", 6, 4);
    chk("g_len4", int'(bus.o_Len), 4);

    // Held grow saturates at MAX_LEN
    bus.i_Dir = 2'b00; bus.i_Grow = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wait_step(n);
      chk("sat_lat", n, 4);
      head("sat_head", 6, 3 - s);
      chk("sat_len", int'(bus.o_Len), (s == 0) ? 5 : 6);
    end
    bus.i_Grow = 1'b0;
`ifndef SNAKE_WRAP_EN
    expect_death("wall_u", 4);
    head("wall_u_head", 6, 0);
    chk("wall_u_len", int'(bus.o_Len), 6);
`endif

    // Tail chase is legal when not growing
    do_reset();
    bus.i_Dir = 2'b11;
    start();
    bus.i_Grow = 1'b1; cyc(); bus.i_Grow = 1'b0;
    wait_step(n);
    head("tc_s1", 5, 4);
    chk("tc_len", int'(bus.o_Len), 4);
    bus.i_Dir = 2'b00; wait_step(n); head("tc_up", 5, 3);
    bus.i_Dir = 2'b10; wait_step(n); head("tc_left", 4, 3);
    bus.i_Dir = 2'b01; wait_step(n);
    chk("tc_lat", n, 4);
    head("tc_down", 4, 4);
    chk("tc_go", int'(bus.o_Game_Over), 0);
    bus.i_Dir = 2'b11; wait_step(n); head("tc_right", 5, 4);

    // Async reset mid-RUN between ticks
    cyc(); cyc();
    rst = 1'b1; #1;
    head("mrst_head", 4, 4);
    chk("mrst_len", int'(bus.o_Len), 3);
    chk("mrst_step", int'(bus.o_Step), 0);
    chk("mrst_go", int'(bus.o_Game_Over), 0);
    @(posedge clk); #1; rst = 1'b0;
    start();
    wait_step(n);
    chk("mrst_lat", n, 4);
    head("mrst_s1", 5, 4);

    // Growing into the tail is a collision
    do_reset();
    bus.i_Dir = 2'b11;
    start();
    bus.i_Grow = 1'b1; cyc(); bus.i_Grow = 1'b0;
    wait_step(n); head("sc_s1", 5, 4);
    bus.i_Dir = 2'b00; wait_step(n);
    bus.i_Dir = 2'b10; wait_step(n); head("sc_left", 4, 3);
    bus.i_Grow = 1'b1; cyc(); bus.i_Grow = 1'b0;
    bus.i_Dir = 2'b01;
    expect_death("self", 4);
    head("self_head", 4, 3);
    chk("self_len", int'(bus.o_Len), 4);

    // Queries against the dead body (4,3),(5,3),(5,4),(4,4)
    bus.i_Query_X = 3'd4; bus.i_Query_Y = 3'd4; cyc();
    chk("qd_tail_hit", int'(bus.o_Query_Hit), 1);
    chk("qd_tail_head", int'(bus.o_Query_Head), 0);
    bus.i_Query_Y = 3'd3; cyc();
    chk("qd_head_hit", int'(bus.o_Query_Hit), 1);
    chk("qd_head_head", int'(bus.o_Query_Head), 1);
    bus.i_Query_X = 3'd3; cyc();
    chk("qd_empty_hit", int'(bus.o_Query_Hit), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
